// File: rtl/koa_iter_mult_pkg.sv
// Shared definitions for the iterative Karatsuba significand multiplier.
// Holds the FSM state encoding and the state decode used for the ready flag.
package koa_iter_mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_LO  = 3'd1,
    ST_MUL_HI  = 3'd2,
    ST_MUL_MID = 3'd3,
    ST_COMBINE = 3'd4,
    ST_DONE    = 3'd5
  } koa_state_t;

  function automatic logic is_ready_state(input koa_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/koa_half_mult.sv
// Combinational unsigned W x W -> 2W multiplier.
// One instance is time-shared across all three Karatsuba partial products.
module koa_half_mult #(
  parameter int W = 29
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  assign o_p = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

endmodule

// File: rtl/koa_iter_mult.sv
// Multi-cycle Karatsuba significand multiplier: AL*BL, AH*BH and (AH+AL)*(BH+BL)
// are formed one per cycle on a shared half-size multiplier, then combined.
module koa_iter_mult
  import koa_iter_mult_pkg::*;
#(
  parameter int SW = 56
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [2*SW-1:0] sgf_result_o
);

  localparam int LW = SW / 2;
  localparam int HW = SW - LW;
  localparam int MW = HW + 1;
  localparam int RW = 2 * SW;

  koa_state_t       r_state;
  koa_state_t       w_next;
  logic [SW-1:0]    r_a;
  logic [SW-1:0]    r_b;
  logic [2*LW-1:0]  r_p0;
  logic [2*HW-1:0]  r_p2;
  logic [2*MW-1:0]  r_p1;
  logic [RW-1:0]    r_result;
  logic             r_done;
  logic             r_ready;

  logic [HW-1:0]    w_ah;
  logic [HW-1:0]    w_bh;
  logic [LW-1:0]    w_al;
  logic [LW-1:0]    w_bl;
  logic [MW-1:0]    w_mul_a;
  logic [MW-1:0]    w_mul_b;
  logic [2*MW-1:0]  w_prod;
  logic             w_accept;
  logic [RW-1:0]    w_p0_x;
  logic [RW-1:0]    w_p1_x;
  logic [RW-1:0]    w_p2_x;
  logic [RW-1:0]    w_mid;
  logic [RW-1:0]    w_sum;

  assign w_ah     = r_a[SW-1:LW];
  assign w_al     = r_a[LW-1:0];
  assign w_bh     = r_b[SW-1:LW];
  assign w_bl     = r_b[LW-1:0];
  assign w_accept = start_i & r_ready;

  // Shared multiplier operand select; low halves are zero-extended for odd SW.
  always_comb begin
    w_mul_a = {MW{1'b0}};
    w_mul_b = {MW{1'b0}};
    case (r_state)
      ST_MUL_LO: begin
        w_mul_a = {{(MW-LW){1'b0}}, w_al};
        w_mul_b = {{(MW-LW){1'b0}}, w_bl};
      end
      ST_MUL_HI: begin
        w_mul_a = {1'b0, w_ah};
        w_mul_b = {1'b0, w_bh};
      end
      ST_MUL_MID: begin
        w_mul_a = {1'b0, w_ah} + {{(MW-LW){1'b0}}, w_al};
        w_mul_b = {1'b0, w_bh} + {{(MW-LW){1'b0}}, w_bl};
      end
      default: begin
        w_mul_a = {MW{1'b0}};
        w_mul_b = {MW{1'b0}};
      end
    endcase
  end

  koa_half_mult #(.W(MW)) u_half_mult (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // The exact product fits in 2*SW bits, so modular 2*SW-bit arithmetic
  // gives the same value as the wider sum with its zero upper bits dropped.
  assign w_p0_x = {{(RW-2*LW){1'b0}}, r_p0};
  assign w_p1_x = {{(RW-2*MW){1'b0}}, r_p1};
  assign w_p2_x = {{(RW-2*HW){1'b0}}, r_p2};
  assign w_mid  = w_p1_x - w_p2_x - w_p0_x;
  assign w_sum  = (w_p2_x << (2*LW)) + (w_mid << LW) + w_p0_x;

  // Next-state logic; new work is accepted only from IDLE or DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_MUL_LO;
        else          w_next = ST_IDLE;
      end
      ST_MUL_LO:  w_next = ST_MUL_HI;
      ST_MUL_HI:  w_next = ST_MUL_MID;
      ST_MUL_MID: w_next = ST_COMBINE;
      ST_COMBINE: w_next = ST_DONE;
      ST_DONE: begin
        if (w_accept) w_next = ST_MUL_LO;
        else          w_next = ST_IDLE;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  // State, operand, partial-product and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_a      <= {SW{1'b0}};
      r_b      <= {SW{1'b0}};
      r_p0     <= {(2*LW){1'b0}};
      r_p2     <= {(2*HW){1'b0}};
      r_p1     <= {(2*MW){1'b0}};
      r_result <= {RW{1'b0}};
    end else begin
      r_state <= w_next;
      r_ready <= is_ready_state(w_next);
      r_done  <= (r_state == ST_COMBINE);
      if (w_accept) begin
        r_a <= Data_A_i;
        r_b <= Data_B_i;
      end
      case (r_state)
        ST_MUL_LO:  r_p0     <= w_prod[2*LW-1:0];
        ST_MUL_HI:  r_p2     <= w_prod[2*HW-1:0];
        ST_MUL_MID: r_p1     <= w_prod;
        ST_COMBINE: r_result <= w_sum;
        default: ;
      endcase
    end
  end

  assign ready_o      = r_ready;
  assign done_o       = r_done;
  assign sgf_result_o = r_result;

endmodule

// File: tb/tb_koa_iter_mult.sv
// Directed and randomised bench for koa_iter_mult at SW=56 and SW=7.
module tb_koa_iter_mult;

  logic         clk = 1'b0;
  logic         rst;
  logic         start56, start7;
  logic [55:0]  a56, b56;
  logic [6:0]   a7, b7;
  logic         ready56, done56, ready7, done7;
  logic [111:0] res56;
  logic [13:0]  res7;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  koa_iter_mult #(.SW(56)) u_dut56 (
    .clk(clk), .rst(rst), .start_i(start56), .Data_A_i(a56), .Data_B_i(b56),
    .ready_o(ready56), .done_o(done56), .sgf_result_o(res56)
  );

  koa_iter_mult #(.SW(7)) u_dut7 (
    .clk(clk), .rst(rst), .start_i(start7), .Data_A_i(a7), .Data_B_i(b7),
    .ready_o(ready7), .done_o(done7), .sgf_result_o(res7)
  );

  task automatic issue56(input logic [55:0] a, input logic [55:0] b);
    @(negedge clk); a56 = a; b56 = b; start56 = 1'b1;
    @(negedge clk); start56 = 1'b0;
  endtask

  task automatic issue7(input logic [6:0] a, input logic [6:0] b);
    @(negedge clk); a7 = a; b7 = b; start7 = 1'b1;
    @(negedge clk); start7 = 1'b0;
  endtask

  task automatic wait_done56(output int cyc);
    cyc = 0;
    while (done56 !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_done7(output int cyc);
    cyc = 0;
    while (done7 !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; start56 = 1'b0; start7 = 1'b0;
    a56 = '0; b56 = '0; a7 = '0; b7 = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (ready56 !== 1'b1) begin n_fail++; $display("FAIL reset_ready56: got %b expected 1", ready56); end
    n_checks++; if (done56 !== 1'b0) begin n_fail++; $display("FAIL reset_done56: got %b expected 0", done56); end
    n_checks++; if (res56 !== 112'd0) begin n_fail++; $display("FAIL reset_res56: got %0h expected 0", res56); end
    n_checks++; if (res7 !== 14'd0 || ready7 !== 1'b1 || done7 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut7: got res=%0h rdy=%b done=%b expected 0/1/0", res7, ready7, done7);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_max56();
    int cyc;
    logic [111:0] exp_v;
    exp_v = {56'hFF_FFFF_FFFF_FFFE, 56'h00_0000_0000_0001};
    issue56({56{1'b1}}, {56{1'b1}});
    wait_done56(cyc);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL max56_latency: got %0d expected 4", cyc); end
    n_checks++; if (res56 !== exp_v) begin n_fail++; $display("FAIL max56_result: got %0h expected %0h", res56, exp_v); end
    @(negedge clk);
    n_checks++; if (done56 !== 1'b0) begin n_fail++; $display("FAIL max56_done_pulse: got %b expected 0", done56); end
    n_checks++; if (res56 !== exp_v) begin n_fail++; $display("FAIL max56_hold: got %0h expected %0h", res56, exp_v); end
  endtask

  task automatic test_small7();
    int cyc;
    issue7(7'd127, 7'd127);
    wait_done7(cyc);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL small7_latency: got %0d expected 4", cyc); end
    n_checks++; if (res7 !== 14'h3F01) begin n_fail++; $display("FAIL small7_max: got %0h expected 3f01", res7); end
    issue7(7'd0, 7'd99);
    wait_done7(cyc);
    n_checks++; if (res7 !== 14'd0 || cyc !== 4) begin
      n_fail++; $display("FAIL small7_zero: got %0h cyc %0d expected 0 cyc 4", res7, cyc);
    end
    issue7(7'd85, 7'd42);
    wait_done7(cyc);
    n_checks++; if (res7 !== 14'd3570) begin n_fail++; $display("FAIL small7_mixed: got %0d expected 3570", res7); end
  endtask

  task automatic test_back_to_back();
    logic exp_flag;
    @(negedge clk); a56 = 56'd3; b56 = 56'd5; start56 = 1'b1;
    @(negedge clk); a56 = 56'd100; b56 = 56'd200;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_flag = (k == 4) || (k == 9);
      n_checks++; if (done56 !== exp_flag) begin n_fail++; $display("FAIL b2b_done k=%0d: got %b expected %b", k, done56, exp_flag); end
      n_checks++; if (ready56 !== exp_flag) begin n_fail++; $display("FAIL b2b_ready k=%0d: got %b expected %b", k, ready56, exp_flag); end
      if (k >= 4 && k <= 8) begin
        n_checks++; if (res56 !== 112'd15) begin n_fail++; $display("FAIL b2b_first k=%0d: got %0d expected 15", k, res56); end
      end
      if (k == 9) begin
        n_checks++; if (res56 !== 112'd20000) begin n_fail++; $display("FAIL b2b_second: got %0d expected 20000", res56); end
      end
    end
    start56 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_midstart();
    logic saw_done;
    issue56(56'd11, 56'd13);
    @(negedge clk);
    @(negedge clk); a56 = 56'd999; b56 = 56'd7; start56 = 1'b1;
    @(negedge clk); start56 = 1'b0;
    @(negedge clk);
    n_checks++; if (done56 !== 1'b1 || res56 !== 112'd143) begin
      n_fail++; $display("FAIL midstart_result: got done=%b res=%0d expected done=1 res=143", done56, res56);
    end
    saw_done = 1'b0;
    repeat (6) begin @(negedge clk); if (done56 === 1'b1) saw_done = 1'b1; end
    n_checks++; if (saw_done !== 1'b0 || ready56 !== 1'b1) begin
      n_fail++; $display("FAIL midstart_no_extra: got done_seen=%b ready=%b expected 0/1", saw_done, ready56);
    end
    n_checks++; if (res56 !== 112'd143) begin n_fail++; $display("FAIL midstart_hold: got %0d expected 143", res56); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic saw_done;
    issue56(56'd1000, 56'd2000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (res56 !== 112'd0 || ready56 !== 1'b1 || done56 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got res=%0d rdy=%b done=%b expected 0/1/0", res56, ready56, done56);
    end
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin @(negedge clk); if (done56 === 1'b1) saw_done = 1'b1; end
    n_checks++; if (saw_done !== 1'b0 || res56 !== 112'd0) begin
      n_fail++; $display("FAIL rstmid_no_done: got done_seen=%b res=%0d expected 0/0", saw_done, res56);
    end
    issue56(56'd7, 56'd9);
    wait_done56(cyc);
    n_checks++; if (res56 !== 112'd63 || cyc !== 4) begin
      n_fail++; $display("FAIL rstmid_next_op: got %0d cyc %0d expected 63 cyc 4", res56, cyc);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [63:0]  r64a, r64b;
    logic [55:0]  ra, rb;
    logic [111:0] e56;
    logic [6:0]   sa, sb;
    logic [13:0]  e7;
    for (int i = 0; i < 100; i++) begin
      r64a = {$urandom(), $urandom()};
      r64b = {$urandom(), $urandom()};
      ra = r64a[55:0]; rb = r64b[55:0];
      e56 = {56'd0, ra} * {56'd0, rb};
      issue56(ra, rb);
      wait_done56(cyc);
      n_checks++; if (res56 !== e56) begin
        n_fail++; $display("FAIL rand56 %0d: A=%0h B=%0h got %0h expected %0h", i, ra, rb, res56, e56);
      end
      sa = 7'($urandom_range(127, 0));
      sb = 7'($urandom_range(127, 0));
      e7 = {7'd0, sa} * {7'd0, sb};
      issue7(sa, sb);
      wait_done7(cyc);
      n_checks++; if (res7 !== e7) begin
        n_fail++; $display("FAIL rand7 %0d: A=%0d B=%0d got %0d expected %0d", i, sa, sb, res7, e7);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_max56();
    test_small7();
    test_back_to_back();
    test_ignore_midstart();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
